capture_readout_ctrl: RTL

//  Sequences one acquisition of the DataStorage block, all in the ReadClock domain.
//  - On command, it issues a stretched WriteStrobe to start a capture.
//  - It then drains the 8-bit converter output byte-by-byte through ReadEnable.
//  - Each byte goes out on a valid/ready stream to the UART transmitter.
//  - It checks the 4-byte start signature, counts bytes and flags timeouts.
//  - It is the only master of WriteStrobe and ReadEnable.

---
 rtl/capture_readout_ctrl_pkg.sv | 33 +++
 rtl/capture_readout_ctrl_cycle_timer.sv | 27 ++
 rtl/capture_readout_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/capture_readout_ctrl_pkg.sv
// Shared definitions for the capture/readout sequencer: DataStorage states,
// start-of-frame signature and the local FSM state set.
package capture_readout_ctrl_pkg;

    typedef enum logic [1:0] {
        STORAGE_RESET  = 2'b00,
        READY_TO_STORE = 2'b01,
        STORING_DATA   = 2'b10,
        SENDING_DATA   = 2'b11
    } storage_state_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STROBE,
        ST_WAIT_DATA,
        ST_FETCH,
        ST_WAIT_VALID,
        ST_SEND,
        ST_DONE
    } state_t;

    localparam int unsigned SIG_LEN = 4;

    function automatic logic [7:0] sig_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    sig_byte = 8'hFF;
            2'd1:    sig_byte = 8'h80;
            2'd2:    sig_byte = 8'h7F;
            default: sig_byte = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/capture_readout_ctrl_cycle_timer.sv
// Loadable down-counter; done is high whenever the count has reached zero.
module cycle_timer #(
    parameter int unsigned MAX_COUNT = 4,
    parameter int unsigned WIDTH     = $clog2(MAX_COUNT) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             done
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/capture_readout_ctrl.sv
// Sequences one DataStorage acquisition: capture strobe, byte-wise drain of the
// converter, valid/ready hand-off to the UART, signature check and timeouts.
module capture_readout_ctrl
    import capture_readout_ctrl_pkg::*;
#(
    parameter int unsigned STROBE_CYCLES  = 4,
    parameter int unsigned FRAME_BYTES    = 4100,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        ArmCmd,
    input  logic        AbortCmd,
    input  logic [1:0]  StorageState,
    input  logic        DataReadyToSend,
    input  logic [7:0]  StorageDataOut,
    input  logic        StorageDataValid,
    output logic        WriteStrobe,
    output logic        ReadEnable,
    output logic [7:0]  TxData,
    output logic        TxValid,
    input  logic        TxReady,
    output logic [15:0] ByteCount,
    output logic        Busy,
    output logic        FrameDone,
    output logic        HeaderError,
    output logic        Timeout,
    output logic        ArmRejected
);

    localparam int unsigned STB_W = $clog2(STROBE_CYCLES) + 1;
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES) + 1;

    state_t      state, next_state;
    logic [7:0]  tx_data;
    logic [15:0] byte_count;
    logic [15:0] byte_count_inc;
    logic        header_error;
    logic        arm_rejected;
    logic        wv_late;
    logic        arm_accept;
    logic        arm_reject;
    logic        handshake;
    logic        stb_done;
    logic        tmo_done;
    logic        stb_load;
    logic        tmo_load;

    // Both timers reload on the cycle their state is entered.
    assign stb_load = (next_state == ST_STROBE)    && (state != ST_STROBE);
    assign tmo_load = (next_state == ST_WAIT_DATA) && (state != ST_WAIT_DATA);

    cycle_timer #(
        .MAX_COUNT (STROBE_CYCLES),
        .WIDTH     (STB_W)
    ) u_strobe_timer (
        .clk        (Clock),
        .rst        (Reset),
        .load       (stb_load),
        .load_value (STB_W'(STROBE_CYCLES - 1)),
        .done       (stb_done)
    );

    cycle_timer #(
        .MAX_COUNT (TIMEOUT_CYCLES),
        .WIDTH     (TMO_W)
    ) u_timeout_timer (
        .clk        (Clock),
        .rst        (Reset),
        .load       (tmo_load),
        .load_value (TMO_W'(TIMEOUT_CYCLES)),
        .done       (tmo_done)
    );

    assign byte_count_inc = (byte_count == 16'hFFFF) ? byte_count : byte_count + 16'd1;

    always_comb begin
        next_state  = state;
        WriteStrobe = 1'b0;
        ReadEnable  = 1'b0;
        TxValid     = 1'b0;
        FrameDone   = 1'b0;
        Timeout     = 1'b0;
        Busy        = (state != ST_IDLE);
        arm_accept  = 1'b0;
        arm_reject  = 1'b0;
        handshake   = 1'b0;

        case (state)
            ST_IDLE: begin
                if (ArmCmd && !AbortCmd) begin
                    if (StorageState == READY_TO_STORE) begin
                        arm_accept = 1'b1;
                        next_state = ST_STROBE;
                    end else begin
                        arm_reject = 1'b1;
                    end
                end
            end
            ST_STROBE: begin
                WriteStrobe = 1'b1;
                if (stb_done) next_state = ST_WAIT_DATA;
            end
            ST_WAIT_DATA: begin
                if (tmo_done) begin
                    Timeout    = 1'b1;
                    next_state = ST_IDLE;
                end else if (DataReadyToSend) begin
                    next_state = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // Re-qualified so a read is never issued into an empty converter.
                if (DataReadyToSend) begin
                    ReadEnable = 1'b1;
                    next_state = ST_WAIT_VALID;
                end else begin
                    next_state = ST_WAIT_DATA;
                end
            end
            ST_WAIT_VALID: begin
                if (StorageDataValid)  next_state = ST_SEND;
                else if (wv_late)      next_state = ST_WAIT_DATA;
            end
            ST_SEND: begin
                TxValid = 1'b1;
                if (TxReady) begin
                    handshake = 1'b1;
                    if (byte_count_inc == 16'(FRAME_BYTES)) next_state = ST_DONE;
                    else if (DataReadyToSend)               next_state = ST_FETCH;
                    else                                    next_state = ST_WAIT_DATA;
                end
            end
            ST_DONE: begin
                FrameDone  = 1'b1;
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase

        if (ArmCmd && !AbortCmd && (state != ST_IDLE)) arm_reject = 1'b1;
        if (AbortCmd) next_state = ST_IDLE;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state        <= ST_IDLE;
            tx_data      <= '0;
            byte_count   <= '0;
            header_error <= 1'b0;
            arm_rejected <= 1'b0;
            wv_late      <= 1'b0;
        end else begin
            state        <= next_state;
            arm_rejected <= arm_reject;
            wv_late      <= (state == ST_WAIT_VALID) && (next_state == ST_WAIT_VALID);
            if ((state == ST_WAIT_VALID) && StorageDataValid) tx_data <= StorageDataOut;
            if (arm_accept) begin
                byte_count   <= '0;
                header_error <= 1'b0;
            end else if (handshake) begin
                byte_count <= byte_count_inc;
                if ((byte_count < 16'(SIG_LEN)) && (tx_data != sig_byte(byte_count[1:0])))
                    header_error <= 1'b1;
            end
        end
    end

    assign TxData      = tx_data;
    assign ByteCount   = byte_count;
    assign HeaderError = header_error;
    assign ArmRejected = arm_rejected;

endmodule
